// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM strobe responder and its users.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_ACCESS = 2'd1,
    RD_HOLD   = 2'd2,
    WR_ACTIVE = 2'd3
  } resp_state_t;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_READ_LAT = 1;
  localparam int DEF_WE_MIN   = 2;

  // Wide enough for the largest legal READ_LAT / WE_MIN (4).
  localparam int CNT_W = 3;

  localparam logic [15:0] LANE_MASK_UPPER = 16'hFF00;
  localparam logic [15:0] LANE_MASK_LOWER = 16'h00FF;

  // Active-low byte enables to a 16-bit keep-mask.
  function automatic logic [15:0] lane_mask(input logic ub_n, input logic lb_n);
    lane_mask = (ub_n ? 16'h0000 : LANE_MASK_UPPER) |
                (lb_n ? 16'h0000 : LANE_MASK_LOWER);
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// DEPTH x 16 word store split into two byte lanes, each with its own write
// enable; synchronous write and a registered read port.
module sram_byte_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic [1:0]        Wr_en,
  input  logic [ADDR_W-1:0] Wr_addr,
  input  logic [15:0]       Wr_data,
  input  logic [ADDR_W-1:0] Rd_addr,
  output logic [15:0]       Rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem_reg [DEPTH];
      logic [7:0] q_reg;

      // Byte-lane write plus registered read of the same lane.
      always_ff @(posedge Clk) begin
        if (Wr_en[gi]) begin
          mem_reg[Wr_addr] <= Wr_data[gi*8 +: 8];
        end
        q_reg <= mem_reg[Rd_addr];
      end

      assign Rd_data[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU's active-low SRAM strobe interface.
// Decodes CE/OE/WE/UB/LB into multi-cycle reads and WE-release writes against
// an on-chip word array, and offers a side port for preloading programs.
module sram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int WE_MIN   = DEF_WE_MIN
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_to_mem,
  output logic [15:0]       Data_from_mem,
  output logic              Data_valid,
  input  logic              Load_en,
  input  logic [ADDR_W-1:0] Load_addr,
  input  logic [15:0]       Load_data,
  output logic              Load_busy,
  output logic              Protocol_err
);

  resp_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       wdata_reg, wdata_next;
  logic              ub_reg, ub_next;
  logic              lb_reg, lb_next;
  logic [15:0]       dout_reg, dout_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;

  logic [1:0]        arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [15:0]       arr_wdata;
  logic [ADDR_W-1:0] arr_raddr;
  logic [15:0]       arr_rdata;

  logic [ADDR_W-1:0] cpu_addr;
  logic              unused_addr_bits;

  // Word address wraps modulo DEPTH; upper MAR bits are don't-care.
  assign cpu_addr         = ADDR[ADDR_W-1:0];
  assign unused_addr_bits = ^ADDR;

  sram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .Clk     (Clk),
    .Wr_en   (arr_we),
    .Wr_addr (arr_waddr),
    .Wr_data (arr_wdata),
    .Rd_addr (arr_raddr),
    .Rd_data (arr_rdata)
  );

  // State and datapath registers; reset aborts any access without a commit.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ub_reg    <= 1'b1;
      lb_reg    <= 1'b1;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      ub_reg    <= ub_next;
      lb_reg    <= lb_next;
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Strobe decode: next state, latches, array port muxing between load and CPU.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    ub_next    = ub_reg;
    lb_next    = lb_reg;
    dout_next  = dout_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    arr_we     = 2'b00;
    arr_waddr  = addr_reg;
    arr_wdata  = wdata_reg;
    arr_raddr  = addr_reg;

    case (state_reg)
      IDLE: begin
        if (Load_en) begin
          // Preload takes the edge; CPU strobes are picked up next cycle.
          arr_we    = 2'b11;
          arr_waddr = Load_addr;
          arr_wdata = Load_data;
        end else if (!Mem_CE && !Mem_WE) begin
          state_next = WR_ACTIVE;
          cnt_next   = CNT_W'(1);
          addr_next  = cpu_addr;
          wdata_next = Data_to_mem;
          ub_next    = Mem_UB;
          lb_next    = Mem_LB;
          if (!Mem_OE) err_next = 1'b1;
        end else if (!Mem_CE && !Mem_OE) begin
          state_next = RD_ACCESS;
          cnt_next   = CNT_W'(1);
          addr_next  = cpu_addr;
          arr_raddr  = cpu_addr;
        end
      end

      RD_ACCESS, RD_HOLD: begin
        if (Mem_CE) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else if (!Mem_WE) begin
          // A write strobe overrides the read in progress.
          state_next = WR_ACTIVE;
          cnt_next   = CNT_W'(1);
          addr_next  = cpu_addr;
          wdata_next = Data_to_mem;
          ub_next    = Mem_UB;
          lb_next    = Mem_LB;
          valid_next = 1'b0;
          if (!Mem_OE) err_next = 1'b1;
        end else if (Mem_OE) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else if (cpu_addr != addr_reg) begin
          state_next = RD_ACCESS;
          cnt_next   = CNT_W'(1);
          addr_next  = cpu_addr;
          arr_raddr  = cpu_addr;
          valid_next = 1'b0;
        end else if (state_reg == RD_ACCESS) begin
          if (cnt_reg == CNT_W'(READ_LAT)) begin
            dout_next  = arr_rdata & lane_mask(Mem_UB, Mem_LB);
            valid_next = 1'b1;
            state_next = RD_HOLD;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      WR_ACTIVE: begin
        if (Mem_CE) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (!Mem_WE) begin
          addr_next  = cpu_addr;
          wdata_next = Data_to_mem;
          ub_next    = Mem_UB;
          lb_next    = Mem_LB;
          if (cnt_reg < CNT_W'(WE_MIN)) cnt_next = cnt_reg + CNT_W'(1);
          if (!Mem_OE) err_next = 1'b1;
        end else begin
          // WE released: commit only if the pulse was long enough.
          state_next = IDLE;
          if (cnt_reg >= CNT_W'(WE_MIN)) begin
            arr_we = {~ub_reg, ~lb_reg};
          end else begin
            err_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign Data_from_mem = dout_reg;
  assign Data_valid    = valid_reg;
  assign Load_busy     = (state_reg != IDLE);
  assign Protocol_err  = err_reg;

endmodule
